// File: rtl/edisk_mapper.sv
// rtl/edisk_mapper.sv - multi-disk E-Disk page mapper: status latch, per-disk control registers, priority page resolve
module edisk_mapper #(
    parameter int          NUM_DISKS = 1,
    parameter logic [7:0]  PORT_BASE = 8'h10,
    parameter int          PAGE_W    = 3
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_sync,
    input  logic [7:0]        cpu_o,
    input  logic [15:0]       addr,
    input  logic              io_wr,
    input  logic              io_rd,
    output logic [PAGE_W-1:0] ed_page,
    output logic [7:0]        status_word,
    output logic [7:0]        data_o,
    output logic              data_oe,
    output logic              conflict
);

    logic [7:0]           r_disk [NUM_DISKS];
    logic [7:0]           r_status;
    logic                 r_old_sync;
    logic                 r_wr_d;
    logic                 r_conflict;

    logic [7:0]           w_off;
    logic                 w_sel;
    logic                 w_wr;
    logic                 w_wr_edge;
    logic                 w_mreq;
    logic                 w_stack;
    logic [NUM_DISKS-1:0] w_hit;
    logic                 w_multi;
    logic [PAGE_W-1:0]    w_page;
    logic                 w_unused;

    // Returns {hit, bank}; a stack hit overrides the window bank within one disk.
    function automatic logic [2:0] disk_map(input logic [7:0] r, input logic [15:0] a,
                                            input logic stack, input logic mreq);
        logic win, ram_hit, stk_hit;
        win     = a[15] & ((a[13] ^ a[14]) | (r[7] & a[13] & a[14]) | (r[6] & ~a[13] & ~a[14]));
        ram_hit = r[5] & win & mreq;
        stk_hit = r[4] & stack & mreq;
        return {ram_hit | stk_hit, stk_hit ? r[3:2] : r[1:0]};
    endfunction

    assign w_off     = addr[7:0] - PORT_BASE;
    assign w_sel     = w_off < 8'(NUM_DISKS);
    assign w_wr      = io_wr & w_sel;
    assign w_wr_edge = w_wr & ~r_wr_d;
    assign w_stack   = r_status[2];
    assign w_mreq    = (r_status[7] | ~r_status[1]) & ~r_status[4] & ~r_status[6];
    assign w_unused  = &{1'b0, r_status[5], r_status[3], r_status[0]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_status   <= 8'h00;
            r_old_sync <= 1'b0;
            r_wr_d     <= 1'b0;
            r_conflict <= 1'b0;
            for (int i = 0; i < NUM_DISKS; i++) r_disk[i] <= 8'h00;
        end else begin
            r_old_sync <= cpu_sync;
            if (cpu_sync & ~r_old_sync) r_status <= cpu_o;
            r_wr_d <= w_wr;
            for (int i = 0; i < NUM_DISKS; i++) begin
                if (w_wr_edge && (w_off == 8'(i))) r_disk[i] <= cpu_o;
            end
            // A register write acknowledges the conflict, even if one is seen this cycle.
            if (w_wr_edge)    r_conflict <= 1'b0;
            else if (w_multi) r_conflict <= 1'b1;
        end
    end

    // Scan high to low so the lowest-indexed hitting disk is the last assignment.
    always_comb begin
        logic [2:0] m;
        w_hit  = '0;
        w_page = '0;
        m      = 3'b000;
        for (int i = NUM_DISKS - 1; i >= 0; i--) begin
            m        = disk_map(r_disk[i], addr, w_stack, w_mreq);
            w_hit[i] = m[2];
            if (m[2]) w_page = PAGE_W'(4 * i + int'(m[1:0]) + 1);
        end
    end

    assign w_multi = |(w_hit & (w_hit - 1'b1));

    always_comb begin
        data_o  = 8'hFF;
        data_oe = 1'b0;
        if (io_rd & w_sel) begin
            data_oe = 1'b1;
            for (int i = 0; i < NUM_DISKS; i++) begin
                if (w_off == 8'(i)) data_o = r_disk[i];
            end
        end
    end

    assign ed_page     = w_page;
    assign status_word = r_status;
    assign conflict    = r_conflict;

endmodule
